// File: rtl/id_ex_stage_pkg.sv
// Shared decode constants, ALU codes, B-source enum and the ID-side decode function
// for the ID/EX pipeline register.
package id_ex_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_BEQ = 4'b0110;
  localparam logic [3:0] ALU_BNQ = 4'b0111;

  typedef enum logic [1:0] {BSRC_RT, BSRC_SEXT, BSRC_ZEXT} bsrc_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    bsrc_e      bsrc;
    logic       dest_rd;
    ctrl_t      ctrl;
  } dec_t;

  // Undecodable encodings fall out as ADD / rt-source with only the illegal flag set.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    case (op)
      OP_RTYPE: begin
        d.dest_rd       = 1'b1;
        d.ctrl.regwrite = 1'b1;
        case (fn)
          FN_ADD:  d.alu_ctrl = ALU_ADD;
          FN_SUB:  d.alu_ctrl = ALU_SUB;
          FN_AND:  d.alu_ctrl = ALU_AND;
          FN_NOR:  d.alu_ctrl = ALU_NOR;
          FN_OR:   d.alu_ctrl = ALU_OR;
          FN_SLT:  d.alu_ctrl = ALU_SLT;
          default: begin
            d.ctrl.regwrite = 1'b0;
            d.ctrl.illegal  = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin d.alu_ctrl = ALU_ADD; d.bsrc = BSRC_SEXT; d.ctrl.regwrite = 1'b1; end
      OP_ANDI: begin d.alu_ctrl = ALU_AND; d.bsrc = BSRC_ZEXT; d.ctrl.regwrite = 1'b1; end
      OP_ORI:  begin d.alu_ctrl = ALU_OR;  d.bsrc = BSRC_ZEXT; d.ctrl.regwrite = 1'b1; end
      OP_SLTI: begin d.alu_ctrl = ALU_SLT; d.bsrc = BSRC_SEXT; d.ctrl.regwrite = 1'b1; end
      OP_LW: begin
        d.bsrc = BSRC_SEXT; d.ctrl.memread = 1'b1; d.ctrl.regwrite = 1'b1;
      end
      OP_SW:   begin d.bsrc = BSRC_SEXT; d.ctrl.memwrite = 1'b1; end
      OP_BEQ:  begin d.alu_ctrl = ALU_BEQ; d.ctrl.branch = 1'b1; end
      OP_BNE:  begin d.alu_ctrl = ALU_BNQ; d.ctrl.branch = 1'b1; end
      default: d.ctrl.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding selector: EX/MEM result, else MEM/WB result, else the
// registered operand. Register 0 never forwards.
module id_ex_stage_fwd_mux #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] idx_i,
  input  logic [DW-1:0] reg_val_i,
  input  logic          exm_regwrite_i,
  input  logic [RW-1:0] exm_rd_i,
  input  logic [DW-1:0] exm_result_i,
  input  logic          mwb_regwrite_i,
  input  logic [RW-1:0] mwb_rd_i,
  input  logic [DW-1:0] mwb_result_i,
  output logic [DW-1:0] val_o
);

  logic exm_hit, mwb_hit;

  assign exm_hit = exm_regwrite_i && (exm_rd_i != '0) && (exm_rd_i == idx_i);
  assign mwb_hit = mwb_regwrite_i && (mwb_rd_i != '0) && (mwb_rd_i == idx_i);
  assign val_o   = exm_hit ? exm_result_i : (mwb_hit ? mwb_result_i : reg_val_i);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, stall/flush and operand forwarding.
// Forwarding muxes are built only when ID_EX_FWD_EN is defined.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          stall,
  input  logic          flush,
  input  logic          exm_regwrite,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_regwrite,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_result,
  output logic          ex_valid,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_ctrl,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_branch,
  output logic          ex_illegal
);

  dec_t          dec;
  ctrl_t         ctrl_d;
  logic [RW-1:0] dest_d;
  logic [DW-1:0] bimm_d;

  logic          valid_q;
  ctrl_t         ctrl_q;
  logic [3:0]    alu_ctrl_q;
  bsrc_e         bsrc_q;
  logic [RW-1:0] dest_q, rs_q, rt_q;
  logic [DW-1:0] rs_data_q, rt_data_q, bimm_q;
  logic [DW-1:0] fwd_a, fwd_b;

  always_comb begin
    dec    = decode(id_opcode, id_funct);
    dest_d = dec.dest_rd ? id_rd : id_rt;
    ctrl_d = dec.ctrl;
    if (dest_d == '0) ctrl_d.regwrite = 1'b0;
    bimm_d = (dec.bsrc == BSRC_ZEXT) ? {{(DW-16){1'b0}}, id_imm}
                                     : {{(DW-16){id_imm[15]}}, id_imm};
  end

  // A bubble only needs to kill valid and the side-effecting controls; data may hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      alu_ctrl_q <= ALU_ADD;
      bsrc_q     <= BSRC_RT;
      dest_q     <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      bimm_q     <= '0;
    end else if (flush || (!stall && !id_valid)) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      alu_ctrl_q <= ALU_ADD;
    end else if (!stall) begin
      valid_q    <= 1'b1;
      ctrl_q     <= ctrl_d;
      alu_ctrl_q <= dec.alu_ctrl;
      bsrc_q     <= dec.bsrc;
      dest_q     <= dest_d;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      bimm_q     <= bimm_d;
    end
  end

`ifdef ID_EX_FWD_EN
  id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .idx_i(rs_q), .reg_val_i(rs_data_q),
    .exm_regwrite_i(exm_regwrite), .exm_rd_i(exm_rd), .exm_result_i(exm_result),
    .mwb_regwrite_i(mwb_regwrite), .mwb_rd_i(mwb_rd), .mwb_result_i(mwb_result),
    .val_o(fwd_a)
  );
  id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .idx_i(rt_q), .reg_val_i(rt_data_q),
    .exm_regwrite_i(exm_regwrite), .exm_rd_i(exm_rd), .exm_result_i(exm_result),
    .mwb_regwrite_i(mwb_regwrite), .mwb_rd_i(mwb_rd), .mwb_result_i(mwb_result),
    .val_o(fwd_b)
  );
`else
  assign fwd_a = rs_data_q;
  assign fwd_b = rt_data_q;
  logic unused_fwd;
  assign unused_fwd = ^{exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd, mwb_result,
                        rs_q, rt_q};
`endif

  assign alu_a         = fwd_a;
  assign alu_b         = (bsrc_q == BSRC_RT) ? fwd_b : bimm_q;
  assign ex_store_data = fwd_b;
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_valid      = valid_q;
  assign ex_dest       = dest_q;
  assign ex_regwrite   = ctrl_q.regwrite;
  assign ex_memread    = ctrl_q.memread;
  assign ex_memwrite   = ctrl_q.memwrite;
  assign ex_branch     = ctrl_q.branch;
  assign ex_illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic
// against an instruction-level reference model.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [5:0]    id_opcode = '0, id_funct = '0;
  logic [DW-1:0] id_rs_data = '0, id_rt_data = '0;
  logic [15:0]   id_imm = '0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic          stall = 1'b0, flush = 1'b0;
  logic          exm_regwrite = 1'b0, mwb_regwrite = 1'b0;
  logic [RW-1:0] exm_rd = '0, mwb_rd = '0;
  logic [DW-1:0] exm_result = '0, mwb_result = '0;
  logic          ex_valid;
  logic [DW-1:0] alu_a, alu_b, ex_store_data;
  logic [3:0]    alu_ctrl;
  logic [RW-1:0] ex_dest;
  logic          ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .stall(stall), .flush(flush),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_branch(ex_branch),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // Reference model: the raw instruction currently held in EX.
  logic          m_valid = 1'b0;
  logic [5:0]    m_op = '0, m_fn = '0;
  logic [15:0]   m_imm = '0;
  logic [RW-1:0] m_rs = '0, m_rt = '0, m_rd = '0;
  logic [DW-1:0] m_rsd = '0, m_rtd = '0;

  typedef struct {
    logic valid, rw, mr, mw, br, ill;
    logic [3:0] ctrl;
    logic [DW-1:0] a, b, sd;
    logic [RW-1:0] dest;
  } exp_t;

  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] idx, input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
`ifdef ID_EX_FWD_EN
    if (mwb_regwrite && mwb_rd != 0 && mwb_rd == idx) r = mwb_result;
    if (exm_regwrite && exm_rd != 0 && exm_rd == idx) r = exm_result;
`endif
    return r;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic [DW-1:0] sx, zx, rtf;
    e = '{default: 0};
    if (!m_valid) return e;
    sx = {{16{m_imm[15]}}, m_imm};
    zx = {16'h0, m_imm};
    rtf = fwd(m_rt, m_rtd);
    e.valid = 1; e.a = fwd(m_rs, m_rsd); e.sd = rtf; e.b = rtf; e.dest = m_rt;
    if (m_op == 6'h00) begin
      e.dest = m_rd; e.rw = 1;
      case (m_fn)
        6'h20: e.ctrl = 4'd0;
        6'h22: e.ctrl = 4'd1;
        6'h24: e.ctrl = 4'd2;
        6'h27: e.ctrl = 4'd3;
        6'h25: e.ctrl = 4'd4;
        6'h2A: e.ctrl = 4'd5;
        default: begin e.ill = 1; e.rw = 0; end
      endcase
    end else begin
      case (m_op)
        6'h08: begin e.ctrl = 4'd0; e.b = sx; e.rw = 1; end
        6'h0C: begin e.ctrl = 4'd2; e.b = zx; e.rw = 1; end
        6'h0D: begin e.ctrl = 4'd4; e.b = zx; e.rw = 1; end
        6'h0A: begin e.ctrl = 4'd5; e.b = sx; e.rw = 1; end
        6'h23: begin e.b = sx; e.mr = 1; e.rw = 1; end
        6'h2B: begin e.b = sx; e.mw = 1; end
        6'h04: begin e.ctrl = 4'd6; e.br = 1; end
        6'h05: begin e.ctrl = 4'd7; e.br = 1; end
        default: e.ill = 1;
      endcase
    end
    if (e.dest == 0) e.rw = 0;
    return e;
  endfunction

  task automatic tick();
    if (flush) m_valid = 1'b0;
    else if (!stall) begin
      if (!id_valid) m_valid = 1'b0;
      else begin
        m_valid = 1'b1; m_op = id_opcode; m_fn = id_funct; m_imm = id_imm;
        m_rs = id_rs; m_rt = id_rt; m_rd = id_rd; m_rsd = id_rs_data; m_rtd = id_rt_data;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [RW-1:0] rs,
                       input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                       input logic [DW-1:0] rsd, input logic [DW-1:0] rtd, input logic [15:0] imm);
    id_valid = 1'b1; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
  endtask

  task automatic clear_fwd();
    exm_regwrite = 0; exm_rd = 0; exm_result = 0; mwb_regwrite = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal, alu_ctrl} !== 10'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0",
        {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal, alu_ctrl});
    end
    n_tests++;
    if ({alu_a, alu_b} !== 64'b0) begin
      n_fail++; $display("FAIL reset_data: alu_a=%h alu_b=%h want 0", alu_a, alu_b);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_decode();
    clear_fwd();
    drive(6'h08, 6'h00, 5'd1, 5'd2, 5'd9, 32'd5, 32'd77, 16'hFFFF);
    tick();
    n_tests++;
    if ({alu_a, alu_b, alu_ctrl, ex_dest, ex_regwrite, ex_valid} !==
        {32'd5, 32'hFFFF_FFFF, 4'b0000, 5'd2, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL addi: a=%h b=%h ctrl=%b dest=%0d rw=%b v=%b",
        alu_a, alu_b, alu_ctrl, ex_dest, ex_regwrite, ex_valid);
    end
    drive(6'h0D, 6'h00, 5'd1, 5'd3, 5'd9, 32'd5, 32'd77, 16'hFFFF);
    tick();
    n_tests++;
    if ({alu_b, alu_ctrl, ex_dest} !== {32'h0000_FFFF, 4'b0100, 5'd3}) begin
      n_fail++; $display("FAIL ori: b=%h ctrl=%b dest=%0d want 0000ffff 0100 3", alu_b, alu_ctrl, ex_dest);
    end
    drive(6'h08, 6'h00, 5'd1, 5'd0, 5'd9, 32'd5, 32'd77, 16'h0001);
    tick();
    n_tests++;
    if (ex_regwrite !== 1'b0) begin
      n_fail++; $display("FAIL dest0_regwrite: got %b want 0", ex_regwrite);
    end
  endtask

  task automatic test_forward();
    logic [DW-1:0] wa;
    clear_fwd();
    drive(6'h00, 6'h20, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 16'h0);
    tick();
    exm_regwrite = 1; exm_rd = 3; exm_result = 32'hAA;
    mwb_regwrite = 1; mwb_rd = 3; mwb_result = 32'hBB;
    #1;
`ifdef ID_EX_FWD_EN
    wa = 32'hAA;
`else
    wa = 32'h11;
`endif
    n_tests++;
    if (alu_a !== wa) begin n_fail++; $display("FAIL fwd_exm_prio: alu_a=%h want %h", alu_a, wa); end
    exm_regwrite = 0;
    #1;
`ifdef ID_EX_FWD_EN
    wa = 32'hBB;
`else
    wa = 32'h11;
`endif
    n_tests++;
    if (alu_a !== wa) begin n_fail++; $display("FAIL fwd_mwb: alu_a=%h want %h", alu_a, wa); end
    drive(6'h00, 6'h20, 5'd0, 5'd4, 5'd5, 32'h33, 32'h22, 16'h0);
    exm_regwrite = 1; exm_rd = 0; mwb_regwrite = 1; mwb_rd = 0;
    tick();
    n_tests++;
    if (alu_a !== 32'h33) begin n_fail++; $display("FAIL fwd_r0: alu_a=%h want 33", alu_a); end
    // sw: store data sees the forwarded rt, alu_b stays on the immediate
    drive(6'h2B, 6'h00, 5'd1, 5'd4, 5'd0, 32'h100, 32'h22, 16'h8000);
    exm_regwrite = 1; exm_rd = 4; exm_result = 32'hCC;
    tick();
`ifdef ID_EX_FWD_EN
    wa = 32'hCC;
`else
    wa = 32'h22;
`endif
    n_tests++;
    if ({ex_store_data, alu_b, ex_memwrite, ex_regwrite} !== {wa, 32'hFFFF_8000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sw_fwd: sd=%h b=%h mw=%b rw=%b want %h ffff8000 1 0",
        ex_store_data, alu_b, ex_memwrite, ex_regwrite, wa);
    end
    clear_fwd();
  endtask

  task automatic test_stall_flush();
    clear_fwd();
    drive(6'h00, 6'h24, 5'd1, 5'd2, 5'd6, 32'hF0, 32'h3C, 16'h0);
    tick();
    stall = 1;
    drive(6'h00, 6'h22, 5'd7, 5'd8, 5'd9, 32'h55, 32'h66, 16'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if ({ex_valid, alu_ctrl, alu_a, alu_b, ex_dest} !== {1'b1, 4'b0010, 32'hF0, 32'h3C, 5'd6}) begin
        n_fail++; $display("FAIL stall_hold%0d: v=%b ctrl=%b a=%h b=%h dest=%0d",
          i, ex_valid, alu_ctrl, alu_a, alu_b, ex_dest);
      end
    end
    flush = 1;
    tick();
    n_tests++;
    if ({ex_valid, ex_regwrite} !== 2'b00) begin
      n_fail++; $display("FAIL flush_over_stall: v=%b rw=%b want 00", ex_valid, ex_regwrite);
    end
    stall = 0; flush = 0;
    tick();
    n_tests++;
    if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL reload: v=%b want 1", ex_valid); end
    id_valid = 0;
    tick();
    n_tests++;
    if ({ex_valid, ex_regwrite} !== 2'b00) begin
      n_fail++; $display("FAIL id_invalid_bubble: v=%b rw=%b want 00", ex_valid, ex_regwrite);
    end
  endtask

  task automatic test_branch_illegal();
    clear_fwd();
    drive(6'h05, 6'h00, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0010);
    tick();
    n_tests++;
    if ({alu_ctrl, ex_branch, ex_regwrite, alu_b} !== {4'b0111, 1'b1, 1'b0, 32'h2}) begin
      n_fail++; $display("FAIL bne: ctrl=%b br=%b rw=%b b=%h", alu_ctrl, ex_branch, ex_regwrite, alu_b);
    end
    drive(6'h3F, 6'h20, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0);
    tick();
    n_tests++;
    if ({ex_illegal, ex_regwrite, ex_memread, ex_memwrite, ex_branch, alu_ctrl} !== {5'b10000, 4'b0}) begin
      n_fail++; $display("FAIL illegal_op: ill=%b rw=%b mr=%b mw=%b br=%b ctrl=%b",
        ex_illegal, ex_regwrite, ex_memread, ex_memwrite, ex_branch, alu_ctrl);
    end
    drive(6'h00, 6'h3F, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0);
    tick();
    n_tests++;
    if ({ex_illegal, ex_regwrite} !== 2'b10) begin
      n_fail++; $display("FAIL illegal_funct: ill=%b rw=%b want 10", ex_illegal, ex_regwrite);
    end
  endtask

  task automatic test_async_reset();
    clear_fwd();
    drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 16'h0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ex_valid, ex_regwrite, alu_ctrl, alu_a} !== {6'b0, 32'b0}) begin
      n_fail++; $display("FAIL async_reset: v=%b rw=%b ctrl=%b a=%h want 0",
        ex_valid, ex_regwrite, alu_ctrl, alu_a);
    end
    m_valid = 1'b0; m_rs = 0; m_rt = 0; m_rsd = 0; m_rtd = 0;
    id_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [5:0] ops [10];
    logic [5:0] fns [6];
    exp_t e;
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h27, 6'h25, 6'h2A};
    for (int i = 0; i < 400; i++) begin
      id_valid   = ($urandom_range(0, 99) < 85);
      id_opcode  = ($urandom_range(0, 19) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
      id_funct   = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 5)];
      id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      exm_regwrite = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_result = $urandom;
      mwb_regwrite = 1'($urandom); mwb_rd = 5'($urandom_range(0, 7)); mwb_result = $urandom;
      tick();
      e = expect_now();
      n_tests++;
      if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal} !==
          {e.valid, e.rw, e.mr, e.mw, e.br, e.ill}) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i,
          {ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_illegal},
          {e.valid, e.rw, e.mr, e.mw, e.br, e.ill});
      end
      if (e.valid) begin
        n_tests++;
        if ({alu_ctrl, alu_a, alu_b, ex_store_data} !== {e.ctrl, e.a, e.b, e.sd}) begin
          n_fail++; $display("FAIL rand_data[%0d]: ctrl=%b a=%h b=%h sd=%h want %b %h %h %h",
            i, alu_ctrl, alu_a, alu_b, ex_store_data, e.ctrl, e.a, e.b, e.sd);
        end
        n_tests++;
        if (ex_dest !== e.dest) begin
          n_fail++; $display("FAIL rand_dest[%0d]: got %0d want %0d", i, ex_dest, e.dest);
        end
      end
    end
    stall = 0; flush = 0; clear_fwd();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_forward();
    test_stall_flush();
    test_branch_illegal();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly upstream of the EX-stage ALU.
- Captures decoded operands and instruction fields from ID and derives the 4-bit ALU control code.
- Selects forwarded operands and presents alu_a/alu_b/alu_ctrl to the ALU each cycle.
- Supports stall (hold) and flush (bubble) from the hazard logic.

Parameters:
- DW, 32, datapath width.
- RW, 5, register-index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_opcode  in  6  instruction[31:26].
- id_funct  in  6  instruction[5:0].
- id_rs_data  in  DW  register-file read port 1.
- id_rt_data  in  DW  register-file read port 2.
- id_imm  in  16  instruction[15:0].
- id_rs, id_rt, id_rd  in  RW each  register indices.
- stall  in  1  hold the current contents.
- flush  in  1  insert a bubble.
- exm_regwrite  in  1  EX/MEM will write a register.
- exm_rd  in  RW  EX/MEM destination index.
- exm_result  in  DW  EX/MEM ALU result.
- mwb_regwrite  in  1  MEM/WB will write a register.
- mwb_rd  in  RW  MEM/WB destination index.
- mwb_result  in  DW  MEM/WB write-back data.
- ex_valid  out  1  EX stage instruction is real.
- alu_a  out  DW  ALU input 1.
- alu_b  out  DW  ALU input 2.
- alu_ctrl  out  4  ALU operation code.
- ex_store_data  out  DW  forwarded rt value, used by sw.
- ex_dest  out  RW  write-back index.
- ex_regwrite, ex_memread, ex_memwrite, ex_branch  out  1 each  registered control bits.
- ex_illegal  out  1  opcode/funct is not decodable.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset:
  - Every registered field goes to 0, so ex_valid=0 and all control bits are 0.
  - alu_ctrl=4'b0000, alu_a=alu_b=0, ex_illegal=0.
- Latency: one cycle from ID inputs to the registered fields. Forwarding muxes are combinational on the registered fields.
- Update priority per edge:
  - flush=1: ex_valid and all control bits clear; data fields are don't-care.
  - else stall=1: hold all fields.
  - else: load from ID.
  - flush wins over stall.
- Decode into alu_ctrl, other controls and dest, for R-type (opcode 0):
  - funct 0x20 add -> 0000.
  - funct 0x22 sub -> 0001.
  - funct 0x24 and -> 0010.
  - funct 0x27 nor -> 0011.
  - funct 0x25 or -> 0100.
  - funct 0x2A slt -> 0101.
  - All six: regwrite=1, dest=rd, B=rt.
- Decode for I-type:
  - addi 0x08 -> 0000, B=sext(imm).
  - andi 0x0C -> 0010, B=zext(imm).
  - ori 0x0D -> 0100, B=zext(imm).
  - slti 0x0A -> 0101, B=sext(imm).
  - All four: regwrite=1, dest=rt.
  - lw 0x23 -> 0000, B=sext(imm), memread=1, regwrite=1, dest=rt.
  - sw 0x2B -> 0000, B=sext(imm), memwrite=1.
  - beq 0x04 -> 0110, B=rt, branch=1.
  - bne 0x05 -> 0111, B=rt, branch=1.
- Any other opcode/funct: ex_illegal=1, alu_ctrl=0000, all write/mem/branch bits 0.
- Register 0 handling: dest=0 forces regwrite=0.
- id_valid=0 loads as a bubble (identical to flush).
- Forwarding, for each of rs and rt:
  - Use exm_result if exm_regwrite && exm_rd!=0 && exm_rd==idx.
  - Else use mwb_result under the same conditions on mwb_*.
  - Else use the registered value.
  - EX/MEM has priority when both match.
  - rt forwarding applies to alu_b only when the B source is rt. It always applies to ex_store_data.
- Reset asserted mid-operation clears everything immediately, without waiting for clk.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding muxes as above.
- Undefined: alu_a, alu_b and ex_store_data come directly from the registered operands. The exm_* and mwb_* ports remain but are ignored.

Decomposition:
- Shared package contents:
  - Opcode and funct constants.
  - 4-bit ALU code constants: ADD, SUB, AND, NOR, OR, SLT, BEQ, BNQ.
  - B-source enum: RT, SEXT, ZEXT.
- One natural sub-module: fwd_mux, a single-operand 3-way forwarding selector, instantiated twice.

Test Plan:
- Reset:
  - Stimulus: drive rst_n=0 asynchronously between edges, with a valid add loaded.
  - Required: ex_valid=0, alu_ctrl=0000 and all control bits 0 before the next clk.
- Decode:
  - Stimulus: addi rs=1 (data 5), imm=0xFFFF.
  - Required: next cycle alu_a=5, alu_b=0xFFFFFFFF, alu_ctrl=0000, dest=rt, regwrite=1.
  - Stimulus: ori with imm=0xFFFF.
  - Required: alu_b=0x0000FFFF.
- Forward priority:
  - Stimulus: registered rs=3; exm_rd=3 with exm_result=0xAA; mwb_rd=3 with mwb_result=0xBB; both regwrite=1.
  - Required: alu_a=0xAA.
  - Stimulus: drop exm_regwrite.
  - Required: alu_a=0xBB.
  - Stimulus: rs=0 with matching rd=0.
  - Required: no forward.
- Stall/flush:
  - Stimulus: stall=1 for 2 cycles with new ID inputs.
  - Required: outputs unchanged.
  - Stimulus: stall=1 and flush=1 together.
  - Required: ex_valid=0 next cycle.
- Branch and illegal:
  - Stimulus: bne.
  - Required: alu_ctrl=0111, branch=1, regwrite=0.
  - Stimulus: opcode 0x3F.
  - Required: ex_illegal=1, all write/mem bits 0.
- Macro off:
  - Stimulus: same scenario as Forward priority without ID_EX_FWD_EN.
  - Required: alu_a equals the registered rs data.
